dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 124 ++++++++++++
 tb/tb_dm_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
//------------------------------------------------------------------------------
// dm_responder: data memory with fixed wait states and byte-lane write merging.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_responder #(
  parameter int DEPTH_LOG2  = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_select,
  input  logic [3:0]  w_eb,
  input  logic [31:0] addr,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        dm_busy,
  output logic        dm_valid
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [3:0]              web_q, web_d;
  logic [31:0]             din_q, din_d;
  logic [31:0]             dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    commit;
  logic [31:0]             cur_word;
  logic [31:0]             merged;
  logic                    unused_addr;

  logic [31:0] mem [DEPTH];

  // Byte offset and address bits beyond the array are intentionally dropped.
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  assign cur_word = mem[idx_q];

  always_comb begin
    merged = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (!web_q[k]) begin
        merged[8*k +: 8] = din_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    web_d   = web_q;
    din_d   = din_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (chip_select) begin
          idx_d   = addr[DEPTH_LOG2+1:2];
          web_d   = w_eb;
          din_d   = DM_in;
          cnt_d   = WAIT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          dout_d  = merged;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Request latches carry no meaning outside ACCESS, so they skip reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    web_q <= web_d;
    din_q <= din_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      mem[idx_q] <= merged;
    end
  end

  assign DM_out   = dout_q;
  assign dm_busy  = (state_q == ACCESS);
  assign dm_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: table of single accesses plus hand-built
// multi-cycle sequences for busy timing, reset abort and back-to-back traffic.
`default_nettype none

module tb_dm_responder;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  web;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        cs    [3];
  logic [3:0]  web   [3];
  logic [31:0] addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        busy  [3];
  logic        valid [3];

  int checks = 0;
  int errors = 0;

  vec_t tbl [13];

  dm_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .chip_select(cs[0]), .w_eb(web[0]), .addr(addr[0]),
    .DM_in(din[0]), .DM_out(dout[0]), .dm_busy(busy[0]), .dm_valid(valid[0])
  );

  dm_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .chip_select(cs[1]), .w_eb(web[1]), .addr(addr[1]),
    .DM_in(din[1]), .DM_out(dout[1]), .dm_busy(busy[1]), .dm_valid(valid[1])
  );

  dm_responder #(.DEPTH_LOG2(14), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .chip_select(cs[2]), .w_eb(web[2]), .addr(addr[2]),
    .DM_in(din[2]), .DM_out(dout[2]), .dm_busy(busy[2]), .dm_valid(valid[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current (idle) cycle and follow it to dm_valid.
  task automatic do_access(input int d, input int wait_c, input logic [31:0] a,
                           input logic [3:0] we, input logic [31:0] data,
                           input logic [31:0] exp, input string name);
    int n;
    bit seen;
    cs[d] = 1'b1; addr[d] = a; web[d] = we; din[d] = data;
    step();
    cs[d] = 1'b0; web[d] = 4'hF;
    n = 1;
    seen = 1'b0;
    while (n <= 40 && !seen) begin
      if (valid[d]) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no dm_valid within 40 cycles", name);
    end else begin
      chk({name, "_latency"}, n, wait_c + 2);
      chk({name, "_data"}, dout[d], exp);
    end
  endtask

  initial begin
    int nvalid;
    tbl[0]  = '{32'h10, 4'b0000, 32'hDEADBEEF, 32'hDEADBEEF, "wr_word"};
    tbl[1]  = '{32'h10, 4'b1111, 32'h0,        32'hDEADBEEF, "rd_word"};
    tbl[2]  = '{32'h20, 4'b0000, 32'h11223344, 32'h11223344, "preload20"};
    tbl[3]  = '{32'h20, 4'b1101, 32'h0000AA00, 32'h1122AA44, "wr_byte1"};
    tbl[4]  = '{32'h20, 4'b1111, 32'h0,        32'h1122AA44, "rd_byte1"};
    tbl[5]  = '{32'h20, 4'b0011, 32'h55660000, 32'h5566AA44, "wr_half_hi"};
    tbl[6]  = '{32'h20, 4'b1111, 32'h0,        32'h5566AA44, "rd_half_hi"};
    tbl[7]  = '{32'h40, 4'b0000, 32'hCAFEF00D, 32'hCAFEF00D, "wr_wrap"};
    tbl[8]  = '{32'h00, 4'b1111, 32'h0,        32'hCAFEF00D, "rd_wrap0"};
    tbl[9]  = '{32'h43, 4'b1111, 32'h0,        32'hCAFEF00D, "rd_wrap43"};
    tbl[10] = '{32'h30, 4'b0000, 32'h01234567, 32'h01234567, "preload30"};
    tbl[11] = '{32'h30, 4'b1010, 32'h00AB00CD, 32'h01AB45CD, "wr_noncontig"};
    tbl[12] = '{32'h30, 4'b1111, 32'h0,        32'h01AB45CD, "rd_noncontig"};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cs[d] = 1'b0; web[d] = 4'hF; addr[d] = 32'h0; din[d] = 32'h0;
    end
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk("reset_dout",  dout[d], 32'h0);
      chk("reset_busy",  {31'b0, busy[d]}, 32'h0);
      chk("reset_valid", {31'b0, valid[d]}, 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_access(0, 1, tbl[i].addr, tbl[i].web, tbl[i].din, tbl[i].exp, tbl[i].name);
    end

    // Reset while in ACCESS must abort the pending write.
    do_access(0, 1, 32'h30, 4'b0000, 32'h01234567, 32'h01234567, "preload30b");
    cs[0] = 1'b1; addr[0] = 32'h30; web[0] = 4'b0000; din[0] = 32'hFFFFFFFF;
    step();
    chk("abort_busy_before", {31'b0, busy[0]}, 32'h1);
    cs[0] = 1'b0; web[0] = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_dout",  dout[0], 32'h0);
    chk("abort_busy",  {31'b0, busy[0]}, 32'h0);
    chk("abort_valid", {31'b0, valid[0]}, 32'h0);
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (valid[0]) nvalid++;
    end
    chk("abort_no_pulse", nvalid, 0);
    do_access(0, 1, 32'h30, 4'b1111, 32'h0, 32'h01234567, "rd_after_abort");

    // WAIT_CYCLES=3: inputs wiggle during ACCESS and must be ignored.
    do_access(1, 3, 32'h50, 4'b0000, 32'h600DF00D, 32'h600DF00D, "w3_pre50");
    do_access(1, 3, 32'h54, 4'b0000, 32'hBAD0BAD0, 32'hBAD0BAD0, "w3_pre54");
    cs[1] = 1'b1; addr[1] = 32'h50; web[1] = 4'b1111; din[1] = 32'h0;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("w3_busy_c%0d", c),  {31'b0, busy[1]},  32'h1);
      chk($sformatf("w3_valid_c%0d", c), {31'b0, valid[1]}, 32'h0);
      cs[1] = c[0]; addr[1] = 32'h54; web[1] = 4'b0000; din[1] = 32'h0;
      step();
    end
    cs[1] = 1'b0; web[1] = 4'hF;
    chk("w3_busy_c5",  {31'b0, busy[1]},  32'h0);
    chk("w3_valid_c5", {31'b0, valid[1]}, 32'h1);
    chk("w3_data_c5",  dout[1], 32'h600DF00D);
    step();
    chk("w3_valid_c6", {31'b0, valid[1]}, 32'h0);
    chk("w3_hold_c6",  dout[1], 32'h600DF00D);
    do_access(1, 3, 32'h54, 4'b1111, 32'h0, 32'hBAD0BAD0, "w3_rd54_untouched");

    // WAIT_CYCLES=0: chip_select held high across the dm_valid cycle.
    do_access(2, 0, 32'h10, 4'b0000, 32'hA5A5A5A5, 32'hA5A5A5A5, "w0_pre10");
    do_access(2, 0, 32'h20, 4'b0000, 32'h3C3C3C3C, 32'h3C3C3C3C, "w0_pre20");
    step();
    cs[2] = 1'b1; addr[2] = 32'h10; web[2] = 4'b1111;
    step();
    chk("b2b_busy_c1", {31'b0, busy[2]}, 32'h1);
    addr[2] = 32'h20;
    step();
    chk("b2b_valid_c2", {31'b0, valid[2]}, 32'h1);
    chk("b2b_data_c2",  dout[2], 32'hA5A5A5A5);
    step();
    cs[2] = 1'b0;
    chk("b2b_busy_c3",  {31'b0, busy[2]},  32'h1);
    chk("b2b_valid_c3", {31'b0, valid[2]}, 32'h0);
    step();
    chk("b2b_valid_c4", {31'b0, valid[2]}, 32'h1);
    chk("b2b_data_c4",  dout[2], 32'h3C3C3C3C);
    step();
    chk("b2b_valid_c5", {31'b0, valid[2]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
